// File: rtl/axis_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_byte_packer
//  Description : AXI4-Stream 8-bit to (8*RATIO)-bit width converter. Packs
//                RATIO input bytes little-endian (first byte in lane 0) into
//                one output word. A flush pulse emits the pending partial
//                word, with m_axis_tkeep marking the valid lanes.
//  Ports       : aclk, areset (sync, active-high)
//                s_axis_tvalid/tready/tdata[7:0]   byte input
//                m_axis_tvalid/tready/tdata/tkeep  word output (registered)
//                flush                             emit partial word
//                stat_bytes/stat_words [31:0]      only with
//                                                  AXIS_PACKER_STATS_EN
//  Options     : `define AXIS_PACKER_STATS_EN to add the byte/word counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_byte_packer #(
    parameter int RATIO = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [7:0]           s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [8*RATIO-1:0]   m_axis_tdata,
    output logic [RATIO-1:0]     m_axis_tkeep,
    input  logic                 flush
`ifdef AXIS_PACKER_STATS_EN
   ,output logic [31:0]          stat_bytes
   ,output logic [31:0]          stat_words
`endif
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [8*RATIO-1:0] r_acc;
    logic               r_flush_pend;
    logic               r_tvalid;
    logic [8*RATIO-1:0] r_tdata;
    logic [RATIO-1:0]   r_tkeep;

    logic               w_last;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_out_free;
    logic               w_complete;
    logic               w_flush_set;
    logic               w_flush_load;
    logic [CNT_W-1:0]   w_cnt_after;
    logic [8*RATIO-1:0] w_acc_next;
    logic [RATIO-1:0]   w_part_keep;

    assign w_last     = (r_cnt == c_last);
    // The only stall besides reset/flush: the word about to complete has
    // nowhere to go because the output register is full and not draining.
    assign s_axis_tready = !areset && !r_flush_pend &&
                           !(w_last && r_tvalid && !m_axis_tready);
    assign w_in_xfer  = s_axis_tvalid && s_axis_tready;
    assign w_out_xfer = r_tvalid && m_axis_tready;
    assign w_out_free = !r_tvalid || m_axis_tready;
    assign w_complete = w_in_xfer && w_last;

    always_comb begin
        w_acc_next  = r_acc;
        w_part_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (w_in_xfer && (r_cnt == CNT_W'(i)))
                w_acc_next[8*i +: 8] = s_axis_tdata;
            w_part_keep[i] = (i < int'(r_cnt));
        end
    end

    // Counter value once this cycle's byte (if any) is accounted for; a
    // flush is only meaningful if that leaves bytes pending, which also
    // covers the case of a flush coinciding with a completing byte.
    assign w_cnt_after  = w_in_xfer ? (w_last ? '0 : r_cnt + CNT_W'(1)) : r_cnt;
    assign w_flush_set  = flush && !r_flush_pend && (w_cnt_after != '0);
    assign w_flush_load = r_flush_pend && w_out_free;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_flush_pend <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
        end else begin
            // Completion only happens with the output free or draining
            // (guaranteed by the ready rule), and never during a pending
            // flush, so the two load sources are mutually exclusive.
            if (w_complete) begin
                r_tdata  <= w_acc_next;
                r_tkeep  <= '1;
                r_tvalid <= 1'b1;
            end else if (w_flush_load) begin
                r_tdata  <= r_acc;
                r_tkeep  <= w_part_keep;
                r_tvalid <= 1'b1;
            end else if (w_out_xfer) begin
                r_tvalid <= 1'b0;
            end

            // Accumulator is cleared after each word so unused lanes of a
            // later partial word read as zero.
            if (w_complete || w_flush_load) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_after;
            end

            if (w_flush_load)
                r_flush_pend <= 1'b0;
            else if (w_flush_set)
                r_flush_pend <= 1'b1;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;

`ifdef AXIS_PACKER_STATS_EN
    logic [31:0] r_stat_bytes;
    logic [31:0] r_stat_words;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_stat_bytes <= '0;
            r_stat_words <= '0;
        end else begin
            if (w_in_xfer)
                r_stat_bytes <= r_stat_bytes + 32'd1;
            if (w_out_xfer)
                r_stat_words <= r_stat_words + 32'd1;
        end
    end

    assign stat_bytes = r_stat_bytes;
    assign stat_words = r_stat_words;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_byte_packer
//  Description : Scoreboard bench for axis_byte_packer with RATIO=4. Directed
//                byte streams push hand-computed {tkeep,tdata} words into a
//                queue; a monitor pops and compares on each output transfer
//                and checks that a stalled output word stays stable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_byte_packer;

    localparam int RATIO = 4;

    logic              clk;
    logic              areset;
    logic              s_tvalid;
    logic              s_tready;
    logic [7:0]        s_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [31:0]       m_tdata;
    logic [3:0]        m_tkeep;
    logic              flush;
`ifdef AXIS_PACKER_STATS_EN
    logic [31:0]       stat_bytes;
    logic [31:0]       stat_words;
`endif

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [35:0]       exp_q[$];

    axis_byte_packer #(.RATIO(RATIO)) dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .flush         (flush)
`ifdef AXIS_PACKER_STATS_EN
       ,.stat_bytes    (stat_bytes)
       ,.stat_words    (stat_words)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] keep, input logic [31:0] data);
        exp_q.push_back({keep, data});
    endtask

    // Waits for the presented byte to be accepted; returns #1 after the
    // accepting edge.
    task automatic wait_accept();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = s_tready;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte %0h not accepted, required accept within 100 cycles", s_tdata);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic fl);
        s_tvalid = 1'b1;
        s_tdata  = b;
        flush    = fl;
        wait_accept();
        s_tvalid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++)
            @(negedge clk);
        check("drain_queue_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        hold_v;
        logic [35:0] hold_d;
        logic [35:0] exp;

        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
        m_tready = 1'b1;
        flush    = 1'b0;

        fork
            begin : monitor
                hold_v = 1'b0;
                hold_d = '0;
                forever begin
                    @(negedge clk);
                    if (areset) begin
                        hold_v = 1'b0;
                    end else begin
                        if (hold_v) begin
                            check("hold_valid", 64'(m_tvalid), 64'd1);
                            check("hold_word", 64'({m_tkeep, m_tdata}), 64'(hold_d));
                        end
                        if (m_tvalid && m_tready) begin
                            if (exp_q.size() == 0) begin
                                n_tests++;
                                n_fail++;
                                $display("FAIL unexpected_beat: got keep %0h data %0h, required no beat", m_tkeep, m_tdata);
                            end else begin
                                exp = exp_q.pop_front();
                                check("out_tdata", 64'(m_tdata), 64'(exp[31:0]));
                                check("out_tkeep", 64'(m_tkeep), 64'(exp[35:32]));
                            end
                        end
                        hold_v = m_tvalid && !m_tready;
                        hold_d = {m_tkeep, m_tdata};
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_m_tkeep", 64'(m_tkeep), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        areset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_s_tready", 64'(s_tready), 64'd1);

        // 1. Two full words, one-cycle latency after the last byte
        push(4'hF, 32'h04030201);
        push(4'hF, 32'h08070605);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b0);
            if (i == 4 || i == 8)
                check("latency_m_tvalid", 64'(m_tvalid), 64'd1);
        end
        wait_drain();

        // 2. Backpressure: byte 8 must stall while word 1 is held
        m_tready = 1'b0;
        push(4'hF, 32'h14131211);
        push(4'hF, 32'h18171615);
        push(4'hF, 32'h1C1B1A19);
        for (int i = 0; i < 7; i++)
            send(8'h11 + 8'(i), 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 8'h18;
        repeat (3) begin
            @(negedge clk);
            check("stall_s_tready", 64'(s_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        wait_accept();
        s_tvalid = 1'b0;
        for (int i = 0; i < 4; i++)
            send(8'h19 + 8'(i), 1'b0);
        wait_drain();

        // 3. Partial word via flush
        push(4'h3, 32'h0000BBAA);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_pend_s_tready", 64'(s_tready), 64'd0);
        wait_drain();
        check("after_flush_s_tready", 64'(s_tready), 64'd1);

        // 4a. Flush with nothing pending: no beat, no stall
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("empty_flush_s_tready", 64'(s_tready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("empty_flush_m_tvalid", 64'(m_tvalid), 64'd0);

        // 4b. Flush coincident with the completing byte
        push(4'hF, 32'h24232221);
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b1);
        check("coinc_flush_s_tready", 64'(s_tready), 64'd1);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check("coinc_flush_no_extra", 64'(m_tvalid), 64'd0);

        // 5. Reset with a held word and a partial word pending
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++)
            send(8'h31 + 8'(i), 1'b0);
        check("pre_reset_m_tvalid", 64'(m_tvalid), 64'd1);
        areset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_m_tvalid", 64'(m_tvalid), 64'd0);
        check("reset_s_tready", 64'(s_tready), 64'd0);
        areset   = 1'b0;
        m_tready = 1'b1;
        push(4'hF, 32'h44434241);
        for (int i = 0; i < 4; i++)
            send(8'h41 + 8'(i), 1'b0);
        wait_drain();

`ifdef AXIS_PACKER_STATS_EN
        // 6. Statistics: 10 bytes + flush -> 2 full words + 1 partial
        areset = 1'b1;
        @(posedge clk);
        #1;
        areset = 1'b0;
        check("stat_bytes_reset", 64'(stat_bytes), 64'd0);
        push(4'hF, 32'h54535251);
        push(4'hF, 32'h58575655);
        push(4'h3, 32'h00005A59);
        for (int i = 0; i < 10; i++)
            send(8'h51 + 8'(i), 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_drain();
        check("stat_bytes", 64'(stat_bytes), 64'd10);
        check("stat_words", 64'(stat_words), 64'd3);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
